// File: rtl/cochlea_scan_pkg.sv
// Shared constants, frame layout helpers and the default frame record for the
// cochlea readout scan-capture block.
package cochlea_scan_pkg;

    localparam int NUM_CH_DEF = 6;
    localparam int RO_W_DEF   = 2;
    localparam int SEQ_W_DEF  = 8;

    // One frame word holds an {I,Q} pair for every channel.
    function automatic int frame_w(input int num_ch, input int ro_w);
        return num_ch * 2 * ro_w;
    endfunction

    function automatic int ch_lsb(input int ch, input int ro_w);
        return ch * 2 * ro_w;
    endfunction

    localparam int FRAME_W_DEF = frame_w(NUM_CH_DEF, RO_W_DEF);

    typedef struct packed {
        logic [FRAME_W_DEF-1:0] data;
        logic [SEQ_W_DEF-1:0]   seq;
    } frame_t;

endpackage

// File: rtl/cochlea_scan_capture_if.sv
// Capture-side bundle: channel readouts, decimation control and the host
// frame handshake. master = capture block, slave = host glue.
interface cochlea_scan_capture_if
    import cochlea_scan_pkg::*;
#(
    parameter int NUM_CH     = NUM_CH_DEF,
    parameter int RO_W       = RO_W_DEF,
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_W      = 16,
    parameter int SEQ_W      = SEQ_W_DEF
);

    logic                            en;
    logic [DIV_W-1:0]                decim;
    logic [NUM_CH*RO_W-1:0]          ro_i;
    logic [NUM_CH*RO_W-1:0]          ro_q;
    logic [NUM_CH*2*RO_W-1:0]        frame_data;
    logic [SEQ_W-1:0]                frame_seq;
    logic                            frame_valid;
    logic                            frame_ready;
    logic [$clog2(FIFO_DEPTH):0]     fifo_level;
    logic                            overflow;
    logic                            overflow_clr;

    modport master (
        input  en, decim, ro_i, ro_q, frame_ready, overflow_clr,
        output frame_data, frame_seq, frame_valid, fifo_level, overflow
    );

    modport slave (
        output en, decim, ro_i, ro_q, frame_ready, overflow_clr,
        input  frame_data, frame_seq, frame_valid, fifo_level, overflow
    );

endinterface

// File: rtl/cochlea_scan_fifo.sv
// Show-ahead frame FIFO; a push while full is accepted when a pop happens in
// the same cycle. The head reads as zero while empty.
module cochlea_scan_fifo
    import cochlea_scan_pkg::*;
#(
    parameter int  DEPTH = 8,
    parameter type T     = frame_t
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic                      pop,
    input  T                          din,
    output T                          dout,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    T               mem [DEPTH];
    logic [AW-1:0]  wptr;
    logic [AW-1:0]  rptr;
    logic           wr_en;
    logic           rd_en;

    assign full  = (level == LW'(DEPTH));
    assign empty = (level == '0);
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (wr_en) wptr <= wptr + AW'(1);
            if (rd_en) rptr <= rptr + AW'(1);
            case ({wr_en, rd_en})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr] <= din;
    end

    always_comb begin
        dout = '0;
        if (!empty) dout = mem[rptr];
    end

endmodule

// File: rtl/cochlea_scan_capture.sv
// Readout aggregator: synchronises all channel I/Q words, takes decimated
// snapshots and queues them as sequence-numbered frames. Define
// COCHLEA_SCAN_DELTA_EN to queue only snapshots that differ from the last one.
module cochlea_scan_capture
    import cochlea_scan_pkg::*;
#(
    parameter int NUM_CH     = NUM_CH_DEF,
    parameter int RO_W       = RO_W_DEF,
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_W      = 16,
    parameter int SEQ_W      = SEQ_W_DEF
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    cochlea_scan_capture_if.master bus
);

    localparam int CH_W  = NUM_CH * RO_W;
    localparam int FW    = frame_w(NUM_CH, RO_W);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [FW-1:0]    data;
        logic [SEQ_W-1:0] seq;
    } cap_frame_t;

    logic [CH_W-1:0]  ro_i_p0, ro_q_p0;
    logic [CH_W-1:0]  ro_i_p1, ro_q_p1;
    logic [FW-1:0]    snap_p1;
    logic             vld_p1;
    logic [DIV_W-1:0] cnt;
    logic [SEQ_W-1:0] seq;
    logic             push_req;
    logic             pop;
    logic             drop;
    logic             accept;
    logic             fifo_full;
    logic             fifo_empty;
    logic             overflow_r;
    logic [LVL_W-1:0] level;
    cap_frame_t       wr_frame;
    cap_frame_t       head;

    // Stage p0 -> p1: two-flop synchroniser on every readout bit
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ro_i_p0 <= '0;
            ro_q_p0 <= '0;
            ro_i_p1 <= '0;
            ro_q_p1 <= '0;
        end else begin
            ro_i_p0 <= bus.ro_i;
            ro_q_p0 <= bus.ro_q;
            ro_i_p1 <= ro_i_p0;
            ro_q_p1 <= ro_q_p0;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_pack
        assign snap_p1[ch_lsb(c, RO_W) +: 2*RO_W] =
            {ro_i_p1[c*RO_W +: RO_W], ro_q_p1[c*RO_W +: RO_W]};
    end

    // Stage p1: decimation tick qualifies the synchronised snapshot.
    // decim is compared live, so lowering it below cnt runs cnt to wrap.
    assign vld_p1 = bus.en && (cnt == bus.decim);

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            cnt <= '0;
            seq <= '0;
        end else begin
            if (!bus.en || vld_p1) cnt <= '0;
            else                   cnt <= cnt + DIV_W'(1);
            if (vld_p1) seq <= seq + SEQ_W'(1);
        end
    end

`ifdef COCHLEA_SCAN_DELTA_EN
    logic [FW-1:0] last_snap;
    logic          first_pend;

    assign push_req = vld_p1 && (first_pend || (snap_p1 != last_snap));

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i)    first_pend <= 1'b1;
        else if (accept) first_pend <= 1'b0;
    end

    always_ff @(posedge wb_clk_i) begin
        if (accept) last_snap <= snap_p1;
    end
`else
    assign push_req = vld_p1;
`endif

    assign pop    = !fifo_empty && bus.frame_ready;
    assign drop   = push_req && fifo_full && !pop;
    assign accept = push_req && !drop;

    // A drop in the same cycle as overflow_clr keeps the flag set.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i)              overflow_r <= 1'b0;
        else if (drop)             overflow_r <= 1'b1;
        else if (bus.overflow_clr) overflow_r <= 1'b0;
    end

    assign wr_frame.data = snap_p1;
    assign wr_frame.seq  = seq;

    cochlea_scan_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (cap_frame_t)
    ) u_fifo (
        .clk   (wb_clk_i),
        .rst   (wb_rst_i),
        .push  (accept),
        .pop   (pop),
        .din   (wr_frame),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    assign bus.frame_data  = head.data;
    assign bus.frame_seq   = head.seq;
    assign bus.frame_valid = !fifo_empty;
    assign bus.fifo_level  = level;
    assign bus.overflow    = overflow_r;

endmodule

// File: tb/tb_cochlea_scan_capture.sv
// Randomised bench for cochlea_scan_capture against a queue-based frame model.
module tb_cochlea_scan_capture;
    import cochlea_scan_pkg::*;

    localparam int NUM_CH = 6;
    localparam int RO_W   = 2;
    localparam int DEPTH  = 8;
    localparam int FW     = 24;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    cochlea_scan_capture_if bus ();

    cochlea_scan_capture dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [FW-1:0] data;
        int            seq;
    } mframe_t;

    mframe_t       mq[$];
    int            m_seq   = 0;
    int            m_since = 0;
    bit            m_ovf   = 1'b0;
    bit            m_first = 1'b1;
    logic [FW-1:0] m_s1    = '0;
    logic [FW-1:0] m_s2    = '0;
    logic [FW-1:0] m_last  = '0;

    wire [37:0] dut_view = {bus.frame_valid, bus.fifo_level, bus.overflow,
                            bus.frame_seq, bus.frame_data};

    function automatic logic [FW-1:0] pack(input logic [11:0] i, input logic [11:0] q);
        logic [FW-1:0] r;
        r = '0;
        for (int c = 0; c < NUM_CH; c++) r[c*4 +: 4] = {i[c*2 +: 2], q[c*2 +: 2]};
        return r;
    endfunction

    function automatic logic [37:0] model_view();
        logic [FW-1:0] d;
        logic [7:0]    s;
        d = '0;
        s = '0;
        if (mq.size() > 0) begin
            d = mq[0].data;
            s = 8'(mq[0].seq);
        end
        return {mq.size() > 0, 4'(mq.size()), m_ovf, s, d};
    endfunction

    task automatic model_reset();
        mq.delete();
        m_seq = 0; m_since = 0; m_ovf = 1'b0; m_first = 1'b1;
        m_s1 = '0; m_s2 = '0;
    endtask

    // One clock: the model reacts to the inputs present at the edge.
    task automatic step();
        bit            pop, tick, att, drop, en, clr;
        logic [FW-1:0] snap, cur;
        en   = bus.en;
        clr  = bus.overflow_clr;
        cur  = pack(bus.ro_i, bus.ro_q);
        pop  = (mq.size() > 0) && bus.frame_ready;
        tick = en && ((m_since % 65536) == int'(bus.decim));
        snap = m_s2;
        att  = tick;
`ifdef COCHLEA_SCAN_DELTA_EN
        att  = tick && (m_first || snap != m_last);
`endif
        drop = att && (mq.size() == DEPTH) && !pop;
        @(posedge clk);
        if (pop) void'(mq.pop_front());
        if (att && !drop) begin
            mq.push_back('{snap, m_seq});
            m_last  = snap;
            m_first = 1'b0;
        end
        if (drop) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        if (tick) m_seq = (m_seq + 1) % 256;
        m_since = (!en || tick) ? 0 : m_since + 1;
        m_s2 = m_s1;
        m_s1 = cur;
        #1;
    endtask

    task automatic do_reset();
        bus.en = 1'b0; bus.frame_ready = 1'b0; bus.overflow_clr = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if (dut_view !== 38'h0) begin
            n_err++; $display("FAIL reset_state got %h want %h", dut_view, 38'h0);
        end
    endtask

    task automatic test_basic();
        int nfr = 0;
        do_reset();
        bus.ro_i = 12'b10; bus.ro_q = 12'b01; bus.decim = 16'd3; bus.frame_ready = 1'b1;
        repeat (3) step();
        bus.en = 1'b1;
        for (int k = 0; k < 40; k++) begin
            step();
            n_vec++;
            if (dut_view !== model_view()) begin
                n_err++; $display("FAIL basic_model got %h want %h", dut_view, model_view());
            end
            if (bus.frame_valid) begin
                n_vec++;
                if (bus.frame_data[3:0] !== 4'b1001 || bus.frame_seq !== 8'(nfr) || (k % 4) != 3) begin
                    n_err++;
                    $display("FAIL basic_frame cyc %0d got data %b seq %0d want 1001 seq %0d", k, bus.frame_data[3:0], bus.frame_seq, nfr);
                end
                nfr++;
            end
        end
        n_vec++;
        if (nfr != 10) begin
            n_err++; $display("FAIL basic_count got %0d want 10", nfr);
        end
    endtask

    task automatic test_overflow();
        int want;
        do_reset();
        bus.ro_i = 12'($urandom); bus.ro_q = 12'($urandom); bus.decim = 16'd0;
        bus.en = 1'b1;
        repeat (12) begin
            step();
            n_vec++;
            if (dut_view !== model_view()) begin
                n_err++; $display("FAIL ovf_model got %h want %h", dut_view, model_view());
            end
        end
        n_vec++;
        if (bus.fifo_level !== 4'd8 || bus.overflow !== 1'b1) begin
            n_err++; $display("FAIL ovf_sat got level %0d ovf %b want 8 1", bus.fifo_level, bus.overflow);
        end
        bus.frame_ready = 1'b1;
        for (int j = 0; j <= 8; j++) begin
            want = (j < 8) ? j : 12;
            n_vec++;
            if (bus.frame_seq !== 8'(want) || bus.fifo_level !== 4'd8) begin
                n_err++; $display("FAIL ovf_drain_seq got %0d lvl %0d want %0d lvl 8", bus.frame_seq, bus.fifo_level, want);
            end
            step();
        end
        bus.overflow_clr = 1'b1;
        step();
        bus.overflow_clr = 1'b0;
        repeat (3) begin
            step();
            n_vec++;
            if (bus.fifo_level !== 4'd8 || bus.overflow !== 1'b0 || dut_view !== model_view()) begin
                n_err++; $display("FAIL full_pop got level %0d ovf %b want 8 0", bus.fifo_level, bus.overflow);
            end
        end
        bus.frame_ready = 1'b0; bus.overflow_clr = 1'b1;
        step();
        bus.overflow_clr = 1'b0;
        n_vec++;
        if (bus.overflow !== 1'b1 || bus.fifo_level !== 4'd8) begin
            n_err++; $display("FAIL clr_vs_drop got ovf %b level %0d want 1 8", bus.overflow, bus.fifo_level);
        end
    endtask

    task automatic test_reset_mid();
        int g = 0;
        do_reset();
        bus.ro_i = 12'($urandom); bus.ro_q = 12'($urandom); bus.decim = 16'd1;
        bus.en = 1'b1;
        while (mq.size() < 5 && g < 100) begin
            step(); g++;
            n_vec++;
            if (dut_view !== model_view()) begin
                n_err++; $display("FAIL rmid_model got %h want %h", dut_view, model_view());
            end
        end
        n_vec++;
        if (bus.fifo_level !== 4'd5) begin
            n_err++; $display("FAIL rmid_fill got %0d want 5", bus.fifo_level);
        end
        #3 rst = 1'b1;
        #1;
        n_vec++;
        if (bus.frame_valid !== 1'b0 || bus.fifo_level !== 4'd0 || bus.overflow !== 1'b0) begin
            n_err++; $display("FAIL rmid_async got valid %b level %0d ovf %b want 0 0 0", bus.frame_valid, bus.fifo_level, bus.overflow);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        bus.decim = 16'd0;
        step();
        n_vec++;
        if (bus.frame_valid !== 1'b1 || bus.frame_seq !== 8'd0 || dut_view !== model_view()) begin
            n_err++; $display("FAIL rmid_seq0 got valid %b seq %0d want 1 0", bus.frame_valid, bus.frame_seq);
        end
    endtask

    task automatic test_wrap();
        int nread = 0;
        int prev  = -1;
        do_reset();
        bus.decim = 16'd0; bus.frame_ready = 1'b1; bus.en = 1'b1;
        for (int k = 0; k < 300; k++) begin
            bus.ro_i = 12'(k + 1); bus.ro_q = 12'($urandom);
            step();
            n_vec++;
            if (dut_view !== model_view()) begin
                n_err++; $display("FAIL wrap_model got %h want %h", dut_view, model_view());
            end
            if (bus.frame_valid) begin
                n_vec++;
                if (bus.frame_seq !== 8'((prev + 1) % 256)) begin
                    n_err++; $display("FAIL wrap_seq got %0d want %0d", bus.frame_seq, (prev + 1) % 256);
                end
                prev = int'(bus.frame_seq);
                nread++;
            end
        end
        n_vec++;
        if (nread != 300 || bus.overflow !== 1'b0) begin
            n_err++; $display("FAIL wrap_count got %0d ovf %b want 300 0", nread, bus.overflow);
        end
    endtask

    task automatic test_random();
        int rdy_pct = 50;
        do_reset();
        bus.decim = 16'd2;
        for (int k = 0; k < 600; k++) begin
            if (k % 50 == 0) rdy_pct = $urandom_range(0, 100);
            if ($urandom_range(0, 15) == 0) bus.en = ~bus.en;
            if ($urandom_range(0, 31) == 0) bus.decim = 16'($urandom_range(0, 4));
            if ($urandom_range(0, 1) == 0) begin
                bus.ro_i = 12'($urandom); bus.ro_q = 12'($urandom);
            end
            bus.frame_ready  = ($urandom_range(0, 99) < rdy_pct);
            bus.overflow_clr = ($urandom_range(0, 7) == 0);
            step();
            n_vec++;
            if (dut_view !== model_view()) begin
                n_err++; $display("FAIL rand_model cyc %0d got %h want %h", k, dut_view, model_view());
            end
        end
        bus.overflow_clr = 1'b0;
    endtask

`ifdef COCHLEA_SCAN_DELTA_EN
    task automatic test_delta();
        int g = 0;
        do_reset();
        bus.ro_i = 12'h0; bus.ro_q = 12'($urandom); bus.decim = 16'd3;
        repeat (3) step();
        bus.en = 1'b1;
        while (m_seq < 10 && g < 200) begin step(); g++; end
        bus.ro_i[11:10] = 2'b11;
        while (m_seq < 14 && g < 400) begin
            step(); g++;
            n_vec++;
            if (dut_view !== model_view()) begin
                n_err++; $display("FAIL delta_model got %h want %h", dut_view, model_view());
            end
        end
        n_vec++;
        if (g >= 400 || bus.fifo_level !== 4'd2 || bus.frame_seq !== 8'd0) begin
            n_err++; $display("FAIL delta_count got level %0d seq %0d want 2 0", bus.fifo_level, bus.frame_seq);
        end
        bus.frame_ready = 1'b1;
        step();
        bus.frame_ready = 1'b0;
        n_vec++;
        if (bus.frame_seq !== 8'd10 || bus.frame_data[23:22] !== 2'b11 || bus.fifo_level !== 4'd1) begin
            n_err++; $display("FAIL delta_second got seq %0d bits %b level %0d want 10 11 1", bus.frame_seq, bus.frame_data[23:22], bus.fifo_level);
        end
    endtask
`endif

    initial begin
        bus.en = 1'b0; bus.decim = '0; bus.ro_i = '0; bus.ro_q = '0;
        bus.frame_ready = 1'b0; bus.overflow_clr = 1'b0;
        test_reset();
        test_basic();
        test_overflow();
        test_reset_mid();
        test_wrap();
        test_random();
`ifdef COCHLEA_SCAN_DELTA_EN
        test_delta();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cochlea_scan_capture.md
Name: cochlea_scan_capture

Overview:
- Parametrised readout aggregator for an array of NUM_CH cochlea channels, each exposing RO_W-bit I and Q readout words.
- Synchronises every channel's readout into the wb_clk_i domain and takes periodic decimated snapshots of all channels.
- Stores snapshots as sequence-numbered frames in a FIFO; host drains frames over a valid/ready handshake.
- Replaces fixed, unbuffered per-channel LA wiring; sits between the channel array and LA/Wishbone glue.

Parameters:
- NUM_CH, 6: number of channels.
- RO_W, 2: width of each I and Q readout word.
- FIFO_DEPTH, 8: frame FIFO depth; power of two, at least 2.
- DIV_W, 16: width of the decimation divisor.
- SEQ_W, 8: width of the frame sequence number.

Ports:
- wb_clk_i  in  1  system clock.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- en  in  1  capture enable.
- decim  in  DIV_W  snapshot period minus one, in clocks.
- ro_i  in  NUM_CH*RO_W  channel I readouts, asynchronous; channel c at [c*RO_W +: RO_W].
- ro_q  in  NUM_CH*RO_W  channel Q readouts, asynchronous; same packing as ro_i.
- frame_data  out  NUM_CH*2*RO_W  head frame; channel c at [c*2*RO_W +: 2*RO_W] = {I,Q}.
- frame_seq  out  SEQ_W  sequence number of the head frame.
- frame_valid  out  1  FIFO not empty.
- frame_ready  in  1  host accepts the head frame.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  frames currently stored.
- overflow  out  1  sticky: a frame was dropped.
- overflow_clr  in  1  clears overflow.

Behaviour:
- Reset (asynchronous, active-high) clears all of the following; frame_data and frame_seq read 0 while empty:
  - synchronisers
  - decimation counter
  - sequence counter
  - FIFO pointers
  - overflow, frame_valid, fifo_level
- Synchronisation: 2-flop synchroniser on every ro_i/ro_q bit. An input change is visible in snapshot data 2 clocks later.
- Decimation counter:
  - Held at 0 while en=0.
  - While en=1, counts 0..decim, then wraps to 0.
  - tick = en && (cnt==decim).
  - decim=0 gives a tick every cycle.
  - decim changed mid-count: compared live; if cnt is already past the new decim, the count runs to wrap at 2^DIV_W, then restarts.
- On tick:
  - Snapshot = current synchroniser outputs, tagged with seq.
  - seq increments every tick, wraps to 0 at 2^SEQ_W-1, and increments on dropped frames too, so the host sees the gaps.
- FIFO write:
  - A tick pushes the frame if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
  - Otherwise the frame is dropped and overflow is set.
- Read port (show-ahead):
  - frame_valid = !empty.
  - frame_data/frame_seq are the head entry.
  - Pop when frame_valid && frame_ready.
  - frame_ready while empty has no effect.
- Latency: tick at edge N → frame visible (frame_valid=1 if previously empty) after edge N.
- Simultaneous push and pop: level unchanged.
- overflow_clr: clears overflow. If a drop occurs in the same cycle, set wins.
- en falling: the counter resets and no further ticks occur. FIFO contents and seq are retained. seq resets only on wb_rst_i.
- fifo_level is exact at all times; range 0..FIFO_DEPTH.

Optional Feature:
- Macro: COCHLEA_SCAN_DELTA_EN.
- When defined:
  - Keep a register of the last pushed snapshot.
  - On a tick, push only if the snapshot differs from that register, or if it is the first tick after reset.
  - Unchanged ticks do not push and do not set overflow, but seq still increments.
  - The last-pushed register updates only on an accepted push.
- When undefined: every tick produces a push attempt; no compare register is built.

Decomposition:
- Package cochlea_scan_pkg holds:
  - RO_W/NUM_CH default constants
  - frame word width function
  - frame typedef struct {data, seq}
  - channel field index helper
- Sub-module cochlea_scan_fifo: synchronous show-ahead FIFO of the frame type, with full/empty/level outputs and simultaneous push-on-full-with-pop.

Test Plan:
- Basic capture:
  - Stimulus: reset; en=1, decim=3, ro_i ch0=2'b10, ro_q ch0=2'b01, others 0; frame_ready=1.
  - Required: one frame every 4 clocks; frame_data[3:0]=4'b1001; seq 0,1,2,...
- Overflow:
  - Stimulus: FIFO_DEPTH=8, decim=0, frame_ready=0 for 12 clocks.
  - Required: fifo_level saturates at 8; overflow=1; stored seq 0..7.
  - Then frame_ready=1 → next frame read after the drained entries has seq 12 or later.
- Full plus simultaneous pop:
  - Stimulus: FIFO full with frame_ready=1 and a tick in the same cycle.
  - Required: level stays 8; no overflow.
  - overflow_clr coincident with a drop → overflow stays 1.
- Reset mid-operation:
  - Stimulus: assert wb_rst_i asynchronously with 5 frames queued.
  - Required: frame_valid=0, fifo_level=0, overflow=0 immediately; next frame after release carries seq=0.
- Sequence wrap and decim=0:
  - Stimulus: run 300 ticks with frame_ready=1.
  - Required: seq wraps 255→0; no frame lost.
- Delta mode (COCHLEA_SCAN_DELTA_EN defined):
  - Stimulus: constant inputs for 10 ticks, then change ch5 I to 2'b11.
  - Required: exactly 2 frames pushed, seqs 0 and 10; second frame bits [23:22]=2'b11.
